// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants and the write-strobe decode for the register file
// with busy scoreboard.
package regfile_scoreboard_pkg;

  localparam int                REG_COUNT     = 32;
  localparam int                REG_IDX_W     = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO   = 5'd0;
  localparam int                DEFAULT_WIDTH = 32;

  // One-hot row select; r0 is hardwired so its strobe can never fire.
  function automatic logic [REG_COUNT-1:0] row_select(
    input logic [REG_IDX_W-1:0] idx,
    input logic                 en
  );
    row_select = '0;
    if (en && (idx != REG_ZERO)) row_select[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_row.sv
// One architectural register row: loads on its write strobe, clears
// asynchronously on reset.
module regfile_row
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  assign data_d = wr_en_i ? wr_data_i : data_q;

  // NOTE: register-file rows are reset too, because reads during and right
  // after reset must return 0 rather than power-up garbage.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!ctrl_reset_n) data_q <= '0;
    else               data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file (1W/2R) with writeback bypass and a busy scoreboard
// that flags RAW hazards to decode.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 ctrl_writeEnable,
  input  logic [REG_IDX_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]     data_writeReg,
  input  logic [REG_IDX_W-1:0] ctrl_readRegA,
  input  logic [REG_IDX_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]     data_readRegA,
  output logic [WIDTH-1:0]     data_readRegB,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 busyA,
  output logic                 busyB,
  output logic [REG_COUNT-1:0] busy_vec
);

  logic [REG_COUNT-1:0] wr_strobe;
  logic [REG_COUNT-1:0] set_vec;
  logic [WIDTH-1:0]     row_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic                 fwd_a;
  logic                 fwd_b;

  assign wr_strobe = row_select(ctrl_writeReg, ctrl_writeEnable);
  assign set_vec   = row_select(issue_rd, issue_valid);

  assign row_q[0] = '0;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_row
    regfile_row #(.WIDTH(WIDTH)) u_row (
      .clock       (clock),
      .ctrl_reset_n(ctrl_reset_n),
      .wr_en_i     (wr_strobe[g]),
      .wr_data_i   (data_writeReg),
      .data_o      (row_q[g])
    );
  end

  // Issue beats writeback on the same row: the newer instruction owns it.
  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    busy_d = busy_q;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (set_vec[i])        busy_d[i] = 1'b1;
      else if (wr_strobe[i]) busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) busy_q <= '0;
    else               busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // wr_strobe already excludes r0, so r0 is never forwarded.
  assign fwd_a = BYPASS && wr_strobe[ctrl_readRegA];
  assign fwd_b = BYPASS && wr_strobe[ctrl_readRegB];

  // Outputs are held at 0 for the whole reset, even if a writeback is presented.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    if (ctrl_reset_n) begin
      data_readRegA = fwd_a ? data_writeReg : row_q[ctrl_readRegA];
      data_readRegB = fwd_b ? data_writeReg : row_q[ctrl_readRegB];
    end
  end

  assign busyA = busy_q[ctrl_readRegA] & ~fwd_a & (ctrl_readRegA != REG_ZERO);
  assign busyB = busy_q[ctrl_readRegB] & ~fwd_b & (ctrl_readRegB != REG_ZERO);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing and one non-bypassing
// instance share all stimulus.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] rd_a, rd_b, nb_rd_a, nb_rd_b;
  logic        busy_a, busy_b, nb_busy_a, nb_busy_b;
  logic [31:0] busy_vec, nb_busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  regfile_scoreboard #(.WIDTH(32), .BYPASS(1'b1)) u_dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(rd_a), .data_readRegB(rd_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busyA(busy_a), .busyB(busy_b), .busy_vec(busy_vec)
  );

  regfile_scoreboard #(.WIDTH(32), .BYPASS(1'b0)) u_dut_nb (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(nb_rd_a), .data_readRegB(nb_rd_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busyA(nb_busy_a), .busyB(nb_busy_b), .busy_vec(nb_busy_vec)
  );

  function automatic logic [31:0] fill_val(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0001_0111;
  endfunction

  // Advance to the next falling edge and present idle stimulus.
  task automatic next_cycle();
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    issue_valid      = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h5555_5555;
    ctrl_readRegA    = 5'd3;
    ctrl_readRegB    = 5'd3;
    #1 ctrl_reset_n  = 1'b0;
    #1;
    n_checks++;
    if (rd_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_fwd_gate: got %h want %h", rd_a, 32'h0);
    end
    ctrl_writeEnable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      n_checks++;
      if (rd_a !== 32'h0 || rd_b !== 32'h0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: a=%h b=%h busyA=%b busyB=%b want zeros",
                 i, rd_a, rd_b, busy_a, busy_b);
      end
    end
    n_checks++;
    if (busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy_vec: got %h want %h", busy_vec, 32'h0);
    end
    next_cycle();
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'hDEAD_BEEF;
    next_cycle();
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd5;
    #2;
    n_checks++;
    if (rd_a !== 32'hDEAD_BEEF || rd_b !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL write_read_r5: a=%h b=%h want %h", rd_a, rd_b, 32'hDEAD_BEEF);
    end
    n_checks++;
    if (nb_rd_a !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL write_read_r5_nb: got %h want %h", nb_rd_a, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_reg_zero();
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'hFFFF_FFFF;
    issue_valid      = 1'b1;
    issue_rd         = 5'd0;
    ctrl_readRegA    = 5'd0;
    #2;
    n_checks++;
    if (rd_a !== 32'h0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL r0_same_cycle: a=%h busyA=%b want 0/0", rd_a, busy_a);
    end
    next_cycle();
    #2;
    n_checks++;
    if (rd_a !== 32'h0) begin
      n_fail++; $display("FAIL r0_read: got %h want %h", rd_a, 32'h0);
    end
    n_checks++;
    if (busy_vec !== 32'h0) begin
      n_fail++; $display("FAIL r0_busy_vec: got %h want %h", busy_vec, 32'h0);
    end
  endtask

  task automatic test_bypass();
    // Preload r7 and mark it busy in the same cycle.
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'hAAAA_0000;
    issue_valid      = 1'b1;
    issue_rd         = 5'd7;
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h1234_5678;
    ctrl_readRegA    = 5'd7;
    ctrl_readRegB    = 5'd5;
    #2;
    n_checks++;
    if (rd_a !== 32'h1234_5678 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL bypass_fwd: a=%h busyA=%b want %h/0", rd_a, busy_a, 32'h1234_5678);
    end
    n_checks++;
    if (rd_b !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass_other_port: got %h want %h", rd_b, 32'hDEAD_BEEF);
    end
    n_checks++;
    if (nb_rd_a !== 32'hAAAA_0000 || nb_busy_a !== 1'b1) begin
      n_fail++; $display("FAIL nobypass_old: a=%h busyA=%b want %h/1", nb_rd_a, nb_busy_a, 32'hAAAA_0000);
    end
    next_cycle();
    #2;
    n_checks++;
    if (rd_a !== 32'h1234_5678 || nb_rd_a !== 32'h1234_5678 || busy_vec[7] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_after: a=%h nb=%h busy7=%b want %h/%h/0",
                         rd_a, nb_rd_a, busy_vec[7], 32'h1234_5678, 32'h1234_5678);
    end
  endtask

  task automatic test_set_wins();
    next_cycle();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    next_cycle();
    ctrl_readRegA = 5'd9;
    #2;
    n_checks++;
    if (busy_vec !== 32'h0000_0200 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL issue_r9: vec=%h busyA=%b want %h/1", busy_vec, busy_a, 32'h0000_0200);
    end
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h0BAD_F00D;
    issue_valid      = 1'b1;
    issue_rd         = 5'd9;
    #2;
    n_checks++;
    if (busy_a !== 1'b0 || nb_busy_a !== 1'b1) begin
      n_fail++; $display("FAIL wb_hazard_mask: busyA=%b nb_busyA=%b want 0/1", busy_a, nb_busy_a);
    end
    next_cycle();
    #2;
    n_checks++;
    if (busy_vec !== 32'h0000_0200 || busy_a !== 1'b1 || rd_a !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL set_wins: vec=%h busyA=%b a=%h want %h/1/%h",
                         busy_vec, busy_a, rd_a, 32'h0000_0200, 32'h0BAD_F00D);
    end
  endtask

  task automatic test_independent();
    // Clear r9 while setting r12 in the same cycle.
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'h0000_0009;
    issue_valid      = 1'b1;
    issue_rd         = 5'd12;
    next_cycle();
    ctrl_readRegA = 5'd12;
    ctrl_readRegB = 5'd9;
    #2;
    n_checks++;
    if (busy_vec !== 32'h0000_1000 || busy_a !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL independent: vec=%h busyA=%b busyB=%b want %h/1/0",
                         busy_vec, busy_a, busy_b, 32'h0000_1000);
    end
    // Writeback to a non-busy register still lands; busy unchanged.
    next_cycle();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd20;
    data_writeReg    = 32'hCAFE_0020;
    next_cycle();
    ctrl_readRegA = 5'd20;
    #2;
    n_checks++;
    if (busy_vec !== 32'h0000_1000 || rd_a !== 32'hCAFE_0020) begin
      n_fail++; $display("FAIL nonbusy_wb: vec=%h a=%h want %h/%h", busy_vec, rd_a,
                         32'h0000_1000, 32'hCAFE_0020);
    end
  endtask

  task automatic test_fill_reset();
    for (int i = 1; i < 32; i++) begin
      next_cycle();
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'(i);
      data_writeReg    = fill_val(i);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      issue_valid = 1'b1;
      issue_rd    = (i == 0) ? 5'd3 : (i == 1) ? 5'd15 : 5'd31;
    end
    next_cycle();
    for (int i = 1; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(32 - i);
      #1;
      n_checks++;
      if (rd_a !== fill_val(i) || rd_b !== fill_val(32 - i)) begin
        n_fail++; $display("FAIL fill_read[%0d]: a=%h b=%h want %h/%h",
                           i, rd_a, rd_b, fill_val(i), fill_val(32 - i));
      end
    end
    n_checks++;
    if (busy_vec !== 32'h8000_8008) begin
      n_fail++; $display("FAIL fill_busy_vec: got %h want %h", busy_vec, 32'h8000_8008);
    end
    // Assert reset between edges and look before any rising edge arrives.
    next_cycle();
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd31;
    #2 ctrl_reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy_vec !== 32'h0 || nb_busy_vec !== 32'h0 || rd_a !== 32'h0 || rd_b !== 32'h0) begin
      n_fail++; $display("FAIL midcycle_reset: vec=%h nbvec=%h a=%h b=%h want zeros",
                         busy_vec, nb_busy_vec, rd_a, rd_b);
    end
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      #1;
      n_checks++;
      if (nb_rd_a !== 32'h0) begin
        n_fail++; $display("FAIL reset_cleared[%0d]: got %h want %h", i, nb_rd_a, 32'h0);
      end
    end
    next_cycle();
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_after_reset();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd4;
    data_writeReg    = 32'h4444_0004;
    issue_valid      = 1'b1;
    issue_rd         = 5'd6;
    next_cycle();
    ctrl_readRegA = 5'd4;
    ctrl_readRegB = 5'd15;
    #2;
    n_checks++;
    if (rd_a !== 32'h4444_0004 || rd_b !== 32'h0 || busy_vec !== 32'h0000_0040) begin
      n_fail++; $display("FAIL first_edge: a=%h b=%h vec=%h want %h/0/%h",
                         rd_a, rd_b, busy_vec, 32'h4444_0004, 32'h0000_0040);
    end
  endtask

  initial begin
    ctrl_reset_n     = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    issue_valid      = 1'b0;
    issue_rd         = 5'd0;
    test_reset();
    test_write_read();
    test_reg_zero();
    test_bypass();
    test_set_wins();
    test_independent();
    test_fill_reset();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural register file for the processor: 32 x WIDTH storage, one write port, two read ports.
- Consumes the writeback stage's 5-bit destination index and enable, decoded one-hot to per-row write strobes.
- Also tracks pending writes in a busy scoreboard, so decode can detect RAW hazards.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
WIDTH, 32, data width of each register
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads see only stored values

Ports:
clock  input  1  single clock; all state updates on rising edge
ctrl_reset_n  input  1  asynchronous, active-low reset
ctrl_writeEnable  input  1  writeback valid
ctrl_writeReg  input  5  writeback destination index
data_writeReg  input  WIDTH  writeback data
ctrl_readRegA  input  5  read port A index
ctrl_readRegB  input  5  read port B index
data_readRegA  output  WIDTH  read port A data (combinational)
data_readRegB  output  WIDTH  read port B data (combinational)
issue_valid  input  1  decode issuing an instruction that will write issue_rd
issue_rd  input  5  destination index of issued instruction
busyA  output  1  register A has a pending write not yet available
busyB  output  1  register B has a pending write not yet available
busy_vec  output  32  registered scoreboard, bit i = register i pending

Behaviour:
- Reset: ctrl_reset_n low clears all 32 registers to 0 and busy_vec to 0 immediately, independent of clock. Reset mid-operation discards in-flight writes and issues; first edge after deassertion behaves as a normal cycle.
- While reset is held: data_readRegA/B = 0, busyA/B = 0, busy_vec = 0.
- Write decode: ctrl_writeReg decoded 5-to-32 one-hot, gated by ctrl_writeEnable. Row i loads data_writeReg on the rising edge when its strobe is 1.
- Register 0: strobe forced 0. It always stores and reads 0 and is never busy.
- Read: data_readRegX = row[ctrl_readRegX], purely combinational, zero-cycle latency.
- Bypass (BYPASS=1): if ctrl_writeEnable=1, ctrl_writeReg==ctrl_readRegX and index != 0, then data_readRegX = data_writeReg in the same cycle.
- Both read ports may address the same register; both return identical data.
- Scoreboard update per edge, for each bit i != 0:
  - set = issue_valid & (issue_rd==i)
  - clr = ctrl_writeEnable & (ctrl_writeReg==i)
  - next = set ? 1 : (clr ? 0 : busy_vec[i])
  - Simultaneous set and clear on the same register: set wins. The newer instruction owns the register.
- Issue and writeback to different registers in the same cycle are independent.
- issue_rd==0 is ignored.
- Writeback to a non-busy register still writes data; busy is unchanged (stays 0).
- Hazard outputs: busyX = busy_vec[ctrl_readRegX] & ~(BYPASS & ctrl_writeEnable & ctrl_writeReg==ctrl_readRegX). Forced 0 when ctrl_readRegX==0.
- No other state. No stalls or backpressure generated internally; decode consumes busyA/B.

Decomposition:
- Shared package: REG_COUNT=32, REG_IDX_W=5, REG_ZERO=5'd0, default WIDTH.
- Sub-module regfile_row:
  - One WIDTH-bit register with write strobe, async active-low clear.
  - Instantiated 31 times (rows 1..31); row 0 is constant 0.
- Write-select decode and scoreboard logic live in the top module.

Test Plan:
- Reset then read all 32 indices on both ports -> every read returns 0; busy_vec=0.
- Write 0xDEADBEEF to r5 with ctrl_writeEnable=1, then read A=5, B=5 next cycle -> both return 0xDEADBEEF.
- Write 0xFFFFFFFF to r0, then read A=0 -> returns 0; busy_vec[0] stays 0.
- Same-cycle write r7=0x12345678 with read A=7:
  - BYPASS=1 -> data_readRegA=0x12345678 and busyA=0 in that cycle.
  - BYPASS=0 -> old value returned.
- Issue rd=9 (busy_vec[9]=1, busyA=1 with A=9). Two cycles later, writeback r9 while issue rd=9 in the same cycle -> busy_vec[9] remains 1, r9 holds the written data.
- Fill r1..r31 with distinct values, set several busy bits, pulse ctrl_reset_n low mid-cycle -> registers and busy_vec clear immediately, without waiting for a clock edge.
